// File: rtl/sha_1_digest_serializer.sv
// SHA-1 digest serializer: buffers up to DEPTH 160-bit digests from a
// pulse-only producer and streams each one out as five 32-bit words over a
// valid/ready handshake, marking the fifth word with o_out_last.
module sha_1_digest_serializer #(
    parameter int unsigned DEPTH      = 2,  // legal: 1, 2, 4
    parameter int unsigned WORD_ORDER = 0   // 0: H0 first, 1: H4 first
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [159:0] i_hash_in,
    input  logic         i_hash_valid,
    output logic [31:0]  o_out_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic         o_out_last,
    output logic [2:0]   o_fill_level,
    output logic         o_overflow,
    input  logic         i_clr_overflow
);

    localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);
    localparam logic [2:0]    Depth3  = 3'(DEPTH);

    logic [159:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [2:0]    r_count;
    logic [2:0]    r_widx;
    logic          r_overflow;

    logic          w_valid;
    logic          w_xfer;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [159:0]  w_head;
    logic [2:0]    w_word_sel;
    logic [31:0]   w_word;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign w_valid = (r_count != 3'd0);
    assign w_xfer  = w_valid & i_out_ready;
    assign w_pop   = w_xfer & (r_widx == 3'd4);
    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    assign w_push  = i_hash_valid & ((r_count < Depth3) | w_pop);
    assign w_drop  = i_hash_valid & ~w_push;

    assign w_head     = r_mem[r_rptr];
    assign w_word_sel = (WORD_ORDER != 0) ? (3'd4 - r_widx) : r_widx;

    // Select the 32-bit word of the head entry; index 0 is H0 = [159:128].
    always_comb begin
        w_word = 32'h0;
        case (w_word_sel)
            3'd0:    w_word = w_head[159:128];
            3'd1:    w_word = w_head[127:96];
            3'd2:    w_word = w_head[95:64];
            3'd3:    w_word = w_head[63:32];
            3'd4:    w_word = w_head[31:0];
            default: w_word = 32'h0;
        endcase
    end

    // Outputs decode registered state only; data is zeroed when idle.
    always_comb begin
        o_out_valid  = w_valid;
        o_out_data   = w_valid ? w_word : 32'h0;
        o_out_last   = w_valid & (r_widx == 3'd4);
        o_fill_level = r_count;
        o_overflow   = r_overflow;
    end

    // Digest storage; contents are don't-care until count covers them.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_hash_in;
        end
    end

    // Pointers, occupancy, word index and sticky overflow flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= 3'd0;
            r_widx     <= 3'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_xfer) begin
                r_widx <= w_pop ? 3'd0 : r_widx + 3'd1;
            end
            // Set takes priority over clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule
